// File: rtl/ex_stage_if.sv
// Decode-to-execute bus for the RV32I EX stage: decode fields, forwarding
// inputs from the hazard unit / later stages, and the EX results.
interface ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              FlushE;
    logic              RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, SrcAsrcD, jumpRegD;
    logic [1:0]        ResultSrcD;
    logic [3:0]        ALUControlD;
    logic [2:0]        funct3D;
    logic [XLEN-1:0]   RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
    logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
    logic [1:0]        ForwardAE, ForwardBE;
    logic [XLEN-1:0]   ALUResultM, ResultW;

    logic              RegWriteE, MemWriteE;
    logic [1:0]        ResultSrcE;
    logic [2:0]        funct3E;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic [XLEN-1:0]   PCPlus4E, ALUResultE, WriteDataE, PCTargetE;
    logic              PCSrcE;

    modport master (
        output FlushE, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, SrcAsrcD, jumpRegD,
               ResultSrcD, ALUControlD, funct3D, RD1D, RD2D, PCD, ImmExtD, PCPlus4D,
               Rs1D, Rs2D, RdD, ForwardAE, ForwardBE, ALUResultM, ResultW,
        input  RegWriteE, MemWriteE, ResultSrcE, funct3E, Rs1E, Rs2E, RdE, PCPlus4E,
               ALUResultE, WriteDataE, PCTargetE, PCSrcE
    );

    modport slave (
        input  FlushE, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, SrcAsrcD, jumpRegD,
               ResultSrcD, ALUControlD, funct3D, RD1D, RD2D, PCD, ImmExtD, PCPlus4D,
               Rs1D, Rs2D, RdD, ForwardAE, ForwardBE, ALUResultM, ResultW,
        output RegWriteE, MemWriteE, ResultSrcE, funct3E, Rs1E, Rs2E, RdE, PCPlus4E,
               ALUResultE, WriteDataE, PCTargetE, PCSrcE
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: flushable ID/EX register, operand forwarding, ALU,
// branch/jump resolution and target PC.
module ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic      clk,
    input logic      reset,
    ex_stage_if.slave bus
);
    typedef struct packed {
        logic              regWrite;
        logic              memWrite;
        logic              jump;
        logic              branch;
        logic              aluSrc;
        logic              srcAsrc;
        logic              jumpReg;
        logic [1:0]        resultSrc;
        logic [3:0]        aluControl;
        logic [2:0]        funct3;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   immExt;
        logic [XLEN-1:0]   pcPlus4;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } idex_t;

    idex_t           idex;
    logic [XLEN-1:0] fwdA, fwdB, srcA, srcB, aluResult;
    logic [4:0]      shamt;
    logic            taken;

    // A flushed entry is all-zero, which is exactly a bubble (no write, no redirect).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex <= '0;
        end else if (bus.FlushE) begin
            idex <= '0;
        end else begin
            idex.regWrite   <= bus.RegWriteD;
            idex.memWrite   <= bus.MemWriteD;
            idex.jump       <= bus.JumpD;
            idex.branch     <= bus.BranchD;
            idex.aluSrc     <= bus.ALUSrcD;
            idex.srcAsrc    <= bus.SrcAsrcD;
            idex.jumpReg    <= bus.jumpRegD;
            idex.resultSrc  <= bus.ResultSrcD;
            idex.aluControl <= bus.ALUControlD;
            idex.funct3     <= bus.funct3D;
            idex.rd1        <= bus.RD1D;
            idex.rd2        <= bus.RD2D;
            idex.pc         <= bus.PCD;
            idex.immExt     <= bus.ImmExtD;
            idex.pcPlus4    <= bus.PCPlus4D;
            idex.rs1        <= bus.Rs1D;
            idex.rs2        <= bus.Rs2D;
            idex.rd         <= bus.RdD;
        end
    end

    always_comb begin
        case (bus.ForwardAE)
            2'b01:   fwdA = bus.ResultW;
            2'b10:   fwdA = bus.ALUResultM;
            default: fwdA = idex.rd1;
        endcase
        case (bus.ForwardBE)
            2'b01:   fwdB = bus.ResultW;
            2'b10:   fwdB = bus.ALUResultM;
            default: fwdB = idex.rd2;
        endcase
    end

    assign srcA  = idex.srcAsrc ? idex.pc : fwdA;
    assign srcB  = idex.aluSrc ? idex.immExt : fwdB;
    assign shamt = srcB[4:0];

    always_comb begin
        aluResult = '0;
        case (idex.aluControl)
            4'b0000: aluResult = srcA + srcB;
            4'b0001: aluResult = srcA - srcB;
            4'b0010: aluResult = srcA & srcB;
            4'b0011: aluResult = srcA | srcB;
            4'b0100: aluResult = srcA ^ srcB;
            4'b0101: aluResult = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            4'b0110: aluResult = {{(XLEN-1){1'b0}}, (srcA < srcB)};
            4'b0111: aluResult = srcA << shamt;
            4'b1000: aluResult = srcA >> shamt;
            4'b1001: aluResult = $unsigned($signed(srcA) >>> shamt);
            4'b1010: aluResult = srcB;
            default: aluResult = '0;
        endcase
    end

    // Branch conditions compare the forwarded register values, never the ALU sources.
    always_comb begin
        taken = 1'b0;
        case (idex.funct3)
            3'b000:  taken = (fwdA == fwdB);
            3'b001:  taken = (fwdA != fwdB);
            3'b100:  taken = ($signed(fwdA) < $signed(fwdB));
            3'b101:  taken = ($signed(fwdA) >= $signed(fwdB));
            3'b110:  taken = (fwdA < fwdB);
            3'b111:  taken = (fwdA >= fwdB);
            default: taken = 1'b0;
        endcase
    end

    assign bus.RegWriteE  = idex.regWrite;
    assign bus.MemWriteE  = idex.memWrite;
    assign bus.ResultSrcE = idex.resultSrc;
    assign bus.funct3E    = idex.funct3;
    assign bus.Rs1E       = idex.rs1;
    assign bus.Rs2E       = idex.rs2;
    assign bus.RdE        = idex.rd;
    assign bus.PCPlus4E   = idex.pcPlus4;
    assign bus.ALUResultE = aluResult;
    assign bus.WriteDataE = fwdB;
    assign bus.PCSrcE     = idex.jump | (idex.branch & taken);
    assign bus.PCTargetE  = idex.jumpReg ? ((fwdA + idex.immExt) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                         : (idex.pc + idex.immExt);
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed pipeline scenarios plus random
// instructions compared against a behavioural model of the execute stage.
module tb_ex_stage;
    typedef struct packed {
        logic        regWrite;
        logic        memWrite;
        logic        jump;
        logic        branch;
        logic        aluSrc;
        logic        srcAsrc;
        logic        jumpReg;
        logic [1:0]  resultSrc;
        logic [3:0]  aluCtl;
        logic [2:0]  f3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } instr_t;

    logic   clk;
    logic   reset;
    int     checkCount;
    int     errorCount;
    instr_t mdl;
    instr_t d;
    logic [1:0]  selA, selB;
    logic [31:0] valM, valW;

    ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << b[4:0];
            4'd8:    return a >> b[4:0];
            4'd9:    return a[31] ? ~((~a) >> b[4:0]) : (a >> b[4:0]);
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic refTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] refFwd(input logic [1:0] sel, input logic [31:0] own);
        if (sel == 2'd1) return valW;
        if (sel == 2'd2) return valM;
        return own;
    endfunction

    task automatic setForward(input logic [1:0] a, input logic [1:0] b, input logic [31:0] m, input logic [31:0] w);
        selA = a;
        selB = b;
        valM = m;
        valW = w;
        bus.ForwardAE  = a;
        bus.ForwardBE  = b;
        bus.ALUResultM = m;
        bus.ResultW    = w;
    endtask

    task automatic driveD(input instr_t x);
        bus.RegWriteD   = x.regWrite;
        bus.MemWriteD   = x.memWrite;
        bus.JumpD       = x.jump;
        bus.BranchD     = x.branch;
        bus.ALUSrcD     = x.aluSrc;
        bus.SrcAsrcD    = x.srcAsrc;
        bus.jumpRegD    = x.jumpReg;
        bus.ResultSrcD  = x.resultSrc;
        bus.ALUControlD = x.aluCtl;
        bus.funct3D     = x.f3;
        bus.RD1D        = x.rd1;
        bus.RD2D        = x.rd2;
        bus.PCD         = x.pc;
        bus.ImmExtD     = x.imm;
        bus.PCPlus4D    = x.pc4;
        bus.Rs1D        = x.rs1;
        bus.Rs2D        = x.rs2;
        bus.RdD         = x.rd;
    endtask

    function automatic instr_t randomD();
        instr_t x;
        x = '0;
        x.regWrite  = 1'($urandom_range(0, 1));
        x.memWrite  = 1'($urandom_range(0, 1));
        x.jump      = ($urandom_range(0, 5) == 0);
        x.branch    = 1'($urandom_range(0, 1));
        x.aluSrc    = 1'($urandom_range(0, 1));
        x.srcAsrc   = ($urandom_range(0, 3) == 0);
        x.jumpReg   = 1'($urandom_range(0, 1));
        x.resultSrc = 2'($urandom_range(0, 3));
        x.aluCtl    = 4'($urandom_range(0, 15));
        x.f3        = 3'($urandom_range(0, 7));
        x.rd1       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
        x.rd2       = ($urandom_range(0, 3) == 0) ? x.rd1 : $urandom;
        x.pc        = $urandom & 32'hFFFF_FFFC;
        x.imm       = $urandom;
        x.pc4       = x.pc + 32'd4;
        x.rs1       = 5'($urandom_range(0, 31));
        x.rs2       = 5'($urandom_range(0, 31));
        x.rd        = 5'($urandom_range(0, 31));
        return x;
    endfunction

    // Drive one decode instruction between edges, clock it in, and update the model.
    task automatic applyStimulus(input instr_t x, input logic flush, input logic rst);
        @(negedge clk);
        reset      = rst;
        bus.FlushE = flush;
        driveD(x);
        @(posedge clk);
        if (rst || flush) mdl = '0;
        else              mdl = x;
        #1;
    endtask

    task automatic checkAll(input string tag);
        logic [31:0] fa, fb, sa, sb, target;
        logic        redirect;
        fa       = refFwd(selA, mdl.rd1);
        fb       = refFwd(selB, mdl.rd2);
        sa       = mdl.srcAsrc ? mdl.pc : fa;
        sb       = mdl.aluSrc ? mdl.imm : fb;
        target   = mdl.jumpReg ? ((fa + mdl.imm) & 32'hFFFF_FFFE) : (mdl.pc + mdl.imm);
        redirect = mdl.jump || (mdl.branch && refTaken(mdl.f3, fa, fb));
        checkOutput({tag, ".RegWriteE"},  32'(bus.RegWriteE),  32'(mdl.regWrite));
        checkOutput({tag, ".MemWriteE"},  32'(bus.MemWriteE),  32'(mdl.memWrite));
        checkOutput({tag, ".ResultSrcE"}, 32'(bus.ResultSrcE), 32'(mdl.resultSrc));
        checkOutput({tag, ".funct3E"},    32'(bus.funct3E),    32'(mdl.f3));
        checkOutput({tag, ".Rs1E"},       32'(bus.Rs1E),       32'(mdl.rs1));
        checkOutput({tag, ".Rs2E"},       32'(bus.Rs2E),       32'(mdl.rs2));
        checkOutput({tag, ".RdE"},        32'(bus.RdE),        32'(mdl.rd));
        checkOutput({tag, ".PCPlus4E"},   bus.PCPlus4E,        mdl.pc4);
        checkOutput({tag, ".ALUResultE"}, bus.ALUResultE,      refAlu(mdl.aluCtl, sa, sb));
        checkOutput({tag, ".WriteDataE"}, bus.WriteDataE,      fb);
        checkOutput({tag, ".PCTargetE"},  bus.PCTargetE,       target);
        checkOutput({tag, ".PCSrcE"},     32'(bus.PCSrcE),     32'(redirect));
    endtask

    initial begin
        instr_t br, jalr;
        checkCount = 0;
        errorCount = 0;
        mdl        = '0;
        reset      = 1'b1;
        bus.FlushE = 1'b0;
        setForward(2'd0, 2'd0, 32'd0, 32'd0);
        d = randomD();
        d.regWrite = 1'b1;
        d.jump     = 1'b1;
        d.rd       = 5'd9;
        driveD(d);
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        checkOutput("reset.ALUResult", bus.ALUResultE, 32'd0);
        checkOutput("reset.PCSrc", 32'(bus.PCSrcE), 32'd0);
        checkOutput("reset.PCTarget", bus.PCTargetE, 32'd0);

        d = '0; d.rd1 = 32'd5; d.rd2 = 32'd7; d.regWrite = 1'b1; d.rd = 5'd3;
        applyStimulus(d, 1'b0, 1'b0);
        checkOutput("add", bus.ALUResultE, 32'd12);
        checkAll("add");
        d.aluCtl = 4'b0001;
        applyStimulus(d, 1'b0, 1'b0);
        checkOutput("sub", bus.ALUResultE, 32'hFFFF_FFFE);

        d = '0; d.rd1 = 32'd1; d.imm = 32'd4; d.aluSrc = 1'b1;
        applyStimulus(d, 1'b0, 1'b0);
        setForward(2'b10, 2'b00, 32'd100, 32'd0);
        #1 checkOutput("fwdM", bus.ALUResultE, 32'd104);
        setForward(2'b01, 2'b00, 32'd0, 32'd200);
        #1 checkOutput("fwdW", bus.ALUResultE, 32'd204);
        checkAll("fwd");
        setForward(2'd0, 2'd0, 32'd0, 32'd0);

        br = '0; br.branch = 1'b1; br.f3 = 3'b100; br.rd1 = 32'hFFFF_FFFF; br.rd2 = 32'd1;
        br.pc = 32'h40; br.imm = 32'h10; br.regWrite = 1'b1;
        applyStimulus(br, 1'b0, 1'b0);
        checkOutput("blt.PCSrc", 32'(bus.PCSrcE), 32'd1);
        checkOutput("blt.PCTarget", bus.PCTargetE, 32'h50);
        d = br; d.f3 = 3'b110;
        applyStimulus(d, 1'b0, 1'b0);
        checkOutput("bltu.PCSrc", 32'(bus.PCSrcE), 32'd0);

        jalr = '0; jalr.jumpReg = 1'b1; jalr.jump = 1'b1; jalr.rd1 = 32'h103; jalr.imm = 32'h4;
        jalr.regWrite = 1'b1; jalr.rd = 5'd1;
        applyStimulus(jalr, 1'b0, 1'b0);
        checkOutput("jalr.PCTarget", bus.PCTargetE, 32'h106);
        checkOutput("jalr.PCSrc", 32'(bus.PCSrcE), 32'd1);

        applyStimulus(br, 1'b1, 1'b0);
        checkOutput("flush.PCSrc", 32'(bus.PCSrcE), 32'd0);
        checkOutput("flush.RegWrite", 32'(bus.RegWriteE), 32'd0);

        applyStimulus(jalr, 1'b0, 1'b0);
        applyStimulus(jalr, 1'b1, 1'b1);
        checkAll("flushReset");
        checkOutput("flushReset.PCSrc", 32'(bus.PCSrcE), 32'd0);
        checkOutput("flushReset.RdE", 32'(bus.RdE), 32'd0);

        // Reset between edges must empty ID/EX immediately.
        applyStimulus(jalr, 1'b0, 1'b0);
        checkOutput("preReset.PCSrc", 32'(bus.PCSrcE), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        mdl = '0;
        checkOutput("midReset.PCSrc", 32'(bus.PCSrcE), 32'd0);
        checkOutput("midReset.RegWrite", 32'(bus.RegWriteE), 32'd0);
        checkAll("midReset");

        for (int i = 0; i < 400; i++) begin
            d = randomD();
            applyStimulus(d, ($urandom_range(0, 7) == 0), 1'b0);
            setForward(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            #1 checkAll("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
